dac_output_conditioner: RTL and testbench

DAC_OUTPUT_CONDITIONER -- requirements
Module: dac_output_conditioner

---
 rtl/dac_output_conditioner.sv | 196 +++++++++++++++++++
 tb/tb_dac_output_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_output_conditioner.sv
// Two-channel clamp and slew-rate limiter placed ahead of the DAC driver.
// Optional build macro DAC_COND_CLIP_COUNT_EN adds saturating per-channel clip counters (regs 7/8).
module dac_output_conditioner #(
  parameter logic [7:0]  CMD_SET   = 8'h22,
  parameter logic [7:0]  CMD_GET   = 8'h23,
  parameter logic [15:0] STEP_INIT = 16'h0100
) (
  input  logic               clkD,
  input  logic               rst_in,
  input  logic               cmd_trig_in,
  input  logic [15:0]        cmd_addr_in,
  input  logic [15:0]        cmd_data_in,
  output logic [15:0]        cmd_data_out,
  input  logic               in_valid,
  input  logic signed [15:0] DAC0_target,
  input  logic signed [15:0] DAC1_target,
  output logic signed [15:0] DAC0_out,
  output logic signed [15:0] DAC1_out,
  output logic [1:0]         settled_out,
  output logic [1:0]         clip_out
);

  typedef enum logic [1:0] {HALT, RUN, ZERO} state_t;

  state_t state, state_nxt;

  logic [3:0]  idx;
  logic        set_cmd;
  logic        get_cmd;
  logic [15:0] rd_val;
  logic        unused_addr_bits;

  logic signed [15:0] min_r       [2];
  logic signed [15:0] max_r       [2];
  logic [15:0]        step_r      [2];
  logic               run_r;
  logic               zero_req_r;

  logic signed [15:0] tgt_in      [2];
  logic [16:0]        clamp_res   [2];
  logic signed [15:0] latched_r   [2];
  logic signed [15:0] latched_nxt [2];
  logic signed [15:0] out_r       [2];
  logic signed [15:0] out_nxt     [2];
  logic [1:0]         clip_c;
  logic [1:0]         settled_nxt;

`ifdef DAC_COND_CLIP_COUNT_EN
  logic [15:0] clip_cnt [2];
  logic [1:0]  cnt_clr;
`endif

  assign idx              = cmd_addr_in[3:0];
  assign set_cmd          = cmd_trig_in && (cmd_addr_in[15:8] == CMD_SET);
  assign get_cmd          = cmd_trig_in && (cmd_addr_in[15:8] == CMD_GET);
  assign unused_addr_bits = ^cmd_addr_in[7:4];

  assign tgt_in[0] = DAC0_target;
  assign tgt_in[1] = DAC1_target;
  assign DAC0_out  = out_r[0];
  assign DAC1_out  = out_r[1];

  // Returns {clipped, value}; an inverted window (MIN > MAX) always yields MIN.
  function automatic logic [16:0] clamp_f(input logic signed [15:0] v,
                                          input logic signed [15:0] lo,
                                          input logic signed [15:0] hi);
    logic signed [15:0] r;
    if (lo > hi)      r = lo;
    else if (v < lo)  r = lo;
    else if (v > hi)  r = hi;
    else              r = v;
    return {(r != v), r};
  endfunction

  // Distance is taken in 17 bits so a full-scale swing never wraps; a partial
  // step always lands strictly between cur and tgt, so 16-bit math is exact.
  function automatic logic signed [15:0] slew_f(input logic signed [15:0] cur,
                                                input logic signed [15:0] tgt,
                                                input logic [15:0]        step);
    logic signed [16:0] diff;
    logic [16:0]        mag;
    diff = {tgt[15], tgt} - {cur[15], cur};
    mag  = diff[16] ? 17'(-diff) : 17'(diff);
    if (mag <= {1'b0, step}) return tgt;
    else if (diff[16])       return cur - step;
    else                     return cur + step;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      HALT:    if (run_r) state_nxt = RUN;
      RUN:     if (zero_req_r || !run_r) state_nxt = ZERO;
      ZERO: begin
        if (out_r[0] == 16'sd0 && out_r[1] == 16'sd0) begin
          if (!run_r)           state_nxt = HALT;
          else if (!zero_req_r) state_nxt = RUN;
        end
      end
      default: state_nxt = HALT;
    endcase

    for (int i = 0; i < 2; i++) begin
      clamp_res[i]   = clamp_f(tgt_in[i], min_r[i], max_r[i]);
      clip_c[i]      = clamp_res[i][16];
      latched_nxt[i] = (in_valid && state != HALT) ? clamp_res[i][15:0] : latched_r[i];
      case (state)
        RUN:     out_nxt[i] = slew_f(out_r[i], latched_r[i], step_r[i]);
        ZERO:    out_nxt[i] = slew_f(out_r[i], 16'sd0, step_r[i]);
        default: out_nxt[i] = 16'sd0;
      endcase
      settled_nxt[i] = (state_nxt == RUN) && (out_nxt[i] == latched_nxt[i]);
    end
  end

  always_comb begin
    rd_val = 16'h0000;
    case (idx)
      4'd0:    rd_val = min_r[0];
      4'd1:    rd_val = max_r[0];
      4'd2:    rd_val = step_r[0];
      4'd3:    rd_val = min_r[1];
      4'd4:    rd_val = max_r[1];
      4'd5:    rd_val = step_r[1];
      4'd6:    rd_val = {14'b0, zero_req_r, run_r};
`ifdef DAC_COND_CLIP_COUNT_EN
      4'd7:    rd_val = clip_cnt[0];
      4'd8:    rd_val = clip_cnt[1];
`endif
      default: rd_val = 16'h0000;
    endcase
  end

  // Register writes land at the clock edge, so a sample accepted in the same
  // cycle is still clamped against the previous MIN/MAX.
  always_ff @(posedge clkD or posedge rst_in) begin
    if (rst_in) begin
      state        <= HALT;
      run_r        <= 1'b0;
      zero_req_r   <= 1'b0;
      cmd_data_out <= 16'h0000;
      settled_out  <= 2'b00;
      clip_out     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        min_r[i]     <= 16'sh8000;
        max_r[i]     <= 16'sh7FFF;
        step_r[i]    <= STEP_INIT;
        latched_r[i] <= 16'sd0;
        out_r[i]     <= 16'sd0;
      end
    end else begin
      state       <= state_nxt;
      settled_out <= settled_nxt;
      for (int i = 0; i < 2; i++) begin
        latched_r[i] <= latched_nxt[i];
        out_r[i]     <= out_nxt[i];
      end
      if (in_valid) clip_out <= clip_c;
      if (set_cmd) begin
        case (idx)
          4'd0:    min_r[0]  <= cmd_data_in;
          4'd1:    max_r[0]  <= cmd_data_in;
          4'd2:    step_r[0] <= cmd_data_in;
          4'd3:    min_r[1]  <= cmd_data_in;
          4'd4:    max_r[1]  <= cmd_data_in;
          4'd5:    step_r[1] <= cmd_data_in;
          4'd6: begin
            run_r      <= cmd_data_in[0];
            zero_req_r <= cmd_data_in[1];
          end
          default: ;
        endcase
      end
      if (get_cmd) cmd_data_out <= rd_val;
    end
  end

`ifdef DAC_COND_CLIP_COUNT_EN
  assign cnt_clr = {get_cmd && idx == 4'd8, get_cmd && idx == 4'd7};

  // Read-to-clear wins over saturation; a coincident clamp restarts the count at 1.
  always_ff @(posedge clkD or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) clip_cnt[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt_clr[i])
          clip_cnt[i] <= (in_valid && clip_c[i]) ? 16'h0001 : 16'h0000;
        else if (in_valid && clip_c[i] && clip_cnt[i] != 16'hFFFF)
          clip_cnt[i] <= clip_cnt[i] + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dac_output_conditioner.sv
// Directed bench for dac_output_conditioner with hand-computed expected values.
module tb_dac_output_conditioner;

  localparam logic [7:0] OP_SET = 8'h22;
  localparam logic [7:0] OP_GET = 8'h23;

  logic        clkD = 1'b0;
  logic        rst_in;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] cmd_data_out;
  logic        in_valid;
  logic [15:0] DAC0_target;
  logic [15:0] DAC1_target;
  logic [15:0] DAC0_out;
  logic [15:0] DAC1_out;
  logic [1:0]  settled_out;
  logic [1:0]  clip_out;

  int checks   = 0;
  int failures = 0;
  logic [15:0] rd;

  always #5 clkD = ~clkD;

  dac_output_conditioner dut (
    .clkD         (clkD),
    .rst_in       (rst_in),
    .cmd_trig_in  (cmd_trig_in),
    .cmd_addr_in  (cmd_addr_in),
    .cmd_data_in  (cmd_data_in),
    .cmd_data_out (cmd_data_out),
    .in_valid     (in_valid),
    .DAC0_target  (DAC0_target),
    .DAC1_target  (DAC1_target),
    .DAC0_out     (DAC0_out),
    .DAC1_out     (DAC1_out),
    .settled_out  (settled_out),
    .clip_out     (clip_out)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance the given number of cycles; sampling happens 1 ns after the edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clkD);
    #1;
  endtask

  task automatic setReg(input logic [3:0] idx, input logic [15:0] data);
    cmd_trig_in = 1'b1;
    cmd_addr_in = {OP_SET, 4'h0, idx};
    cmd_data_in = data;
    applyStimulus(1);
    cmd_trig_in = 1'b0;
  endtask

  task automatic getReg(input logic [3:0] idx, output logic [15:0] data);
    cmd_trig_in = 1'b1;
    cmd_addr_in = {OP_GET, 4'h0, idx};
    applyStimulus(1);
    cmd_trig_in = 1'b0;
    data = cmd_data_out;
  endtask

  task automatic sendTarget(input logic [15:0] t0, input logic [15:0] t1);
    in_valid    = 1'b1;
    DAC0_target = t0;
    DAC1_target = t1;
    applyStimulus(1);
    in_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 1'b1; cmd_trig_in = 1'b0; cmd_addr_in = '0; cmd_data_in = '0;
    in_valid = 1'b0; DAC0_target = '0; DAC1_target = '0;
    applyStimulus(2);
    rst_in = 1'b0;
    applyStimulus(1);

    checkOutput("rst_out0", DAC0_out, 16'h0000);
    checkOutput("rst_out1", DAC1_out, 16'h0000);
    checkOutput("rst_settled", 16'(settled_out), 16'h0000);
    checkOutput("rst_clip", 16'(clip_out), 16'h0000);
    checkOutput("rst_rdata", cmd_data_out, 16'h0000);
    getReg(4'd0, rd); checkOutput("rst_min0", rd, 16'h8000);
    getReg(4'd1, rd); checkOutput("rst_max0", rd, 16'h7FFF);
    getReg(4'd2, rd); checkOutput("rst_step0", rd, 16'h0100);
    getReg(4'd5, rd); checkOutput("rst_step1", rd, 16'h0100);
    getReg(4'd6, rd); checkOutput("rst_ctrl", rd, 16'h0000);
    getReg(4'd7, rd); checkOutput("rst_clipcnt0", rd, 16'h0000);

    // Ramp 0 -> 0x400 in 0x100 steps
    setReg(4'd6, 16'h0001);
    applyStimulus(1);
    sendTarget(16'h0400, 16'h0000);
    checkOutput("ramp_lat", DAC0_out, 16'h0000);
    applyStimulus(1); checkOutput("ramp_1", DAC0_out, 16'h0100);
    applyStimulus(1); checkOutput("ramp_2", DAC0_out, 16'h0200);
    applyStimulus(1); checkOutput("ramp_3", DAC0_out, 16'h0300);
    checkOutput("ramp_3_settled", 16'(settled_out), 16'h0002);
    applyStimulus(1); checkOutput("ramp_4", DAC0_out, 16'h0400);
    checkOutput("ramp_4_settled", 16'(settled_out), 16'h0003);

    // Clamp to MAX0
    setReg(4'd1, 16'h1000);
    sendTarget(16'h7FFF, 16'h0000);
    checkOutput("clamp_clip", 16'(clip_out), 16'h0001);
    checkOutput("clamp_start", DAC0_out, 16'h0400);
    applyStimulus(12);
    checkOutput("clamp_final", DAC0_out, 16'h1000);
    checkOutput("clamp_settled", 16'(settled_out), 16'h0003);

    // Two-cycle latency for a small step on channel 1
    sendTarget(16'h1000, 16'h0050);
    checkOutput("lat_n1", DAC1_out, 16'h0000);
    checkOutput("lat_clip", 16'(clip_out), 16'h0000);
    applyStimulus(1);
    checkOutput("lat_n2", DAC1_out, 16'h0050);

    // Simultaneous MAX0 write and sample: old MAX applies
    cmd_trig_in = 1'b1; cmd_addr_in = {OP_SET, 8'h01}; cmd_data_in = 16'h0800;
    in_valid = 1'b1; DAC0_target = 16'h7FFF; DAC1_target = 16'h0050;
    applyStimulus(1);
    cmd_trig_in = 1'b0; in_valid = 1'b0;
    checkOutput("simul_clip", 16'(clip_out), 16'h0001);
    applyStimulus(2);
    checkOutput("simul_out0", DAC0_out, 16'h1000);
    getReg(4'd1, rd); checkOutput("simul_max0", rd, 16'h0800);

    // Inverted window: MIN wins even for a target above MAX
    setReg(4'd0, 16'h0900);
    sendTarget(16'h7000, 16'h0050);
    checkOutput("inv_clip", 16'(clip_out), 16'h0001);
    applyStimulus(7);
    checkOutput("inv_out0", DAC0_out, 16'h0900);
    setReg(4'd0, 16'h8000);
    setReg(4'd1, 16'h7FFF);

    // Full-scale swing without wrap
    setReg(4'd5, 16'hFFFF);
    sendTarget(16'h0900, 16'h7FFF);
    applyStimulus(1);
    checkOutput("swing_pos", DAC1_out, 16'h7FFF);
    sendTarget(16'h0900, 16'h8000);
    applyStimulus(1);
    checkOutput("swing_neg", DAC1_out, 16'h8000);

    // STEP=0 freezes, then mid-slew STEP changes continue without jump
    setReg(4'd5, 16'h0000);
    sendTarget(16'h0900, 16'h0000);
    applyStimulus(3);
    checkOutput("freeze_out1", DAC1_out, 16'h8000);
    checkOutput("freeze_settled", 16'(settled_out), 16'h0001);
    setReg(4'd5, 16'h1000);
    checkOutput("restep_0", DAC1_out, 16'h8000);
    applyStimulus(1); checkOutput("restep_1", DAC1_out, 16'h9000);
    setReg(4'd5, 16'hFFFF);
    checkOutput("restep_2", DAC1_out, 16'hA000);
    applyStimulus(1); checkOutput("restep_3", DAC1_out, 16'h0000);

    // Zero request from 0x300, then return to RUN
    sendTarget(16'h0300, 16'h0000);
    applyStimulus(6);
    checkOutput("zero_pre", DAC0_out, 16'h0300);
    setReg(4'd6, 16'h0003);
    applyStimulus(1); checkOutput("zero_enter", DAC0_out, 16'h0300);
    applyStimulus(1); checkOutput("zero_1", DAC0_out, 16'h0200);
    checkOutput("zero_settled", 16'(settled_out), 16'h0000);
    applyStimulus(1); checkOutput("zero_2", DAC0_out, 16'h0100);
    applyStimulus(1); checkOutput("zero_3", DAC0_out, 16'h0000);
    applyStimulus(1); checkOutput("zero_hold", DAC0_out, 16'h0000);
    setReg(4'd6, 16'h0001);
    applyStimulus(1);
    checkOutput("zero_resume_settled", 16'(settled_out), 16'h0002);
    applyStimulus(1);
    checkOutput("zero_resume_out0", DAC0_out, 16'h0100);

    // run=0 leads to HALT; clip_out still tracks samples there
    setReg(4'd6, 16'h0000);
    applyStimulus(8);
    checkOutput("halt_out0", DAC0_out, 16'h0000);
    setReg(4'd1, 16'h1000);
    sendTarget(16'h7FFF, 16'h0000);
    checkOutput("halt_clip", 16'(clip_out), 16'h0001);
    applyStimulus(3);
    checkOutput("halt_hold", DAC0_out, 16'h0000);
    checkOutput("halt_settled", 16'(settled_out), 16'h0000);

    // Asynchronous reset in the middle of a slew
    setReg(4'd6, 16'h0001);
    applyStimulus(1);
    sendTarget(16'h1000, 16'h0000);
    checkOutput("mid_1", DAC0_out, 16'h0100);
    applyStimulus(2);
    checkOutput("mid_3", DAC0_out, 16'h0300);
    rst_in = 1'b1;
    #1;
    checkOutput("arst_out0", DAC0_out, 16'h0000);
    checkOutput("arst_settled", 16'(settled_out), 16'h0000);
    applyStimulus(1);
    rst_in = 1'b0;
    applyStimulus(1);
    getReg(4'd0, rd); checkOutput("arst_min0", rd, 16'h8000);
    getReg(4'd1, rd); checkOutput("arst_max0", rd, 16'h7FFF);
    getReg(4'd2, rd); checkOutput("arst_step0", rd, 16'h0100);
    getReg(4'd5, rd); checkOutput("arst_step1", rd, 16'h0100);
    getReg(4'd6, rd); checkOutput("arst_ctrl", rd, 16'h0000);
    setReg(4'd6, 16'h0001);
    applyStimulus(4);
    checkOutput("restart_out0", DAC0_out, 16'h0000);
    checkOutput("restart_settled", 16'(settled_out), 16'h0003);

    // Clip counter: three clamped samples, read, read again
    setReg(4'd1, 16'h1000);
    sendTarget(16'h7FFF, 16'h0000);
    sendTarget(16'h7FFF, 16'h0000);
    sendTarget(16'h7FFF, 16'h0000);
    getReg(4'd7, rd);
`ifdef DAC_COND_CLIP_COUNT_EN
    checkOutput("clipcnt_read", rd, 16'h0003);
`else
    checkOutput("clipcnt_read", rd, 16'h0000);
`endif
    getReg(4'd7, rd); checkOutput("clipcnt_cleared", rd, 16'h0000);
    getReg(4'd8, rd); checkOutput("clipcnt1", rd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
